// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state and AXI encodings for the fetch unit
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_DRAIN,
    ST_HALT
  } fetch_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_NORM = 4'b0011;
  localparam logic [2:0] AXI_PROT_INSTR = 3'b100;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_fetch_unit_if.sv
// rtl/axi_fetch_unit_if.sv - AXI4 read-address and read-data channels of the fetch unit
interface axi_fetch_unit_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 13
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer taking a beat of words per cycle, one word out
module fetch_fifo #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 32,
  parameter int LANES      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [LANES-1:0]      push_mask,
  input  logic [LANES*32-1:0]   push_data,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [31:0]           out_data,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [$clog2(DEPTH):0] free_count
);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]           mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic [PW:0]           running;
  logic [PW:0]           push_count;
  logic [PW-1:0]         waddr [LANES];
  logic                  pop_fire;

  // Enabled lanes are packed into consecutive slots starting at wr_ptr.
  always_comb begin
    running = '0;
    for (int i = 0; i < LANES; i++) begin
      waddr[i] = wr_ptr + running[PW-1:0];
      running  = running + (PW+1)'(push_mask[i]);
    end
    push_count = running;
  end

  assign pop_fire   = pop && (count != '0);
  assign out_valid  = (count != '0);
  assign out_data   = mem_data[rd_ptr];
  assign out_pc     = mem_pc[rd_ptr];
  assign free_count = (PW+1)'(DEPTH) - count;

  // Storage write; each word carries its own PC.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_mask[i] && !flush) begin
        mem_data[waddr[i]] <= push_data[32*i +: 32];
        mem_pc[waddr[i]]   <= push_pc + ADDR_WIDTH'(4*i);
      end
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_count[PW-1:0];
      rd_ptr <= rd_ptr + PW'(pop_fire);
      count  <= count + push_count - (PW+1)'(pop_fire);
    end
  end
endmodule

// File: rtl/axi_fetch_unit.sv
// rtl/axi_fetch_unit.sv - instruction fetch engine: AXI4 line bursts into an instruction buffer
module axi_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 13,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] entry,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  halted,
  output logic                  fetch_err,
  axi_fetch_unit_if.master      m_axi
);
  localparam int IPB        = DATA_WIDTH / 32;
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int LINE_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int CREDIT     = BURST_LEN * IPB;
  localparam int PW         = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] fetch_pc, ar_addr, beat_addr;
  logic                  arvalid_q, rready_q, drain_pending;
  logic                  r_fire, beat_bad, resp_err, push_en;
  logic [IPB-1:0]        push_mask;
  logic [PW:0]           free_count;
  logic                  unused_rid;

  assign m_axi.arid    = ID_WIDTH'(0);
  assign m_axi.araddr  = ar_addr;
  assign m_axi.arlen   = 8'(BURST_LEN - 1);
  assign m_axi.arsize  = 3'($clog2(BEAT_BYTES));
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = AXI_CACHE_NORM;
  assign m_axi.arprot  = AXI_PROT_INSTR;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign unused_rid    = ^m_axi.rid;

  assign r_fire   = m_axi.rvalid && rready_q;
  assign resp_err = (m_axi.rresp != AXI_RESP_OKAY);
  assign beat_bad = resp_err || (m_axi.rdata == '0);
  assign push_en  = (state == ST_DATA) && r_fire && !redirect_valid && !beat_bad;

  // Words of the first beat that lie below the target PC are not pushed.
  always_comb begin
    push_mask = '0;
    for (int i = 0; i < IPB; i++) begin
      push_mask[i] = push_en && ((beat_addr + ADDR_WIDTH'(4*i)) >= fetch_pc);
    end
  end

  fetch_fifo #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (FIFO_DEPTH),
    .LANES     (IPB)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push_mask (push_mask),
    .push_data (m_axi.rdata),
    .push_pc   (beat_addr),
    .pop       (instr_valid && instr_ready),
    .out_valid (instr_valid),
    .out_data  (instr_data),
    .out_pc    (instr_pc),
    .free_count(free_count)
  );

  // Fetch sequencer: one line burst at a time; a redirect overrides PC and flags last.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      fetch_pc      <= entry;
      ar_addr       <= '0;
      beat_addr     <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      drain_pending <= 1'b0;
      halted        <= 1'b0;
      fetch_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!redirect_valid && !halted && (free_count >= (PW+1)'(CREDIT))) begin
            state         <= ST_REQ;
            arvalid_q     <= 1'b1;
            ar_addr       <= fetch_pc & ~LINE_MASK;
            beat_addr     <= fetch_pc & ~LINE_MASK;
            drain_pending <= 1'b0;
          end
        end
        ST_REQ: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= (redirect_valid || drain_pending) ? ST_DRAIN : ST_DATA;
          end else if (redirect_valid) begin
            drain_pending <= 1'b1;
          end
        end
        ST_DATA: begin
          if (redirect_valid) begin
            if (r_fire && m_axi.rlast) begin
              rready_q <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              state <= ST_DRAIN;
            end
          end else if (r_fire) begin
            beat_addr <= beat_addr + ADDR_WIDTH'(BEAT_BYTES);
            if (beat_bad) begin
              halted <= 1'b1;
              if (resp_err) fetch_err <= 1'b1;
              if (m_axi.rlast) begin
                rready_q <= 1'b0;
                state    <= ST_HALT;
              end else begin
                state <= ST_DRAIN;
              end
            end else if (m_axi.rlast) begin
              fetch_pc <= ar_addr + ADDR_WIDTH'(LINE_BYTES);
              rready_q <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (r_fire && m_axi.rlast) begin
            rready_q <= 1'b0;
            state    <= (halted && !redirect_valid) ? ST_HALT : ST_IDLE;
          end
        end
        ST_HALT: begin
          if (redirect_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (redirect_valid) begin
        fetch_pc  <= redirect_pc;
        halted    <= 1'b0;
        fetch_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_fetch_unit.sv
// tb/tb_axi_fetch_unit.sv - directed vector bench for axi_fetch_unit
module tb_axi_fetch_unit;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int BL  = 8;
  localparam int FD  = 32;
  localparam int DWB = 128;
  localparam int BLB = 4;
  localparam int FDB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [AW-1:0] entry = 64'h1000;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr_data;
  logic [AW-1:0] instr_pc;
  logic          halted, fetch_err;

  logic          reset_b = 1'b1;
  logic [AW-1:0] entry_b = 64'h1000;
  logic          redirect_valid_b = 1'b0;
  logic [AW-1:0] redirect_pc_b = '0;
  logic          instr_valid_b;
  logic          instr_ready_b = 1'b1;
  logic [31:0]   instr_data_b;
  logic [AW-1:0] instr_pc_b;
  logic          halted_b, fetch_err_b;

  axi_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),  .ID_WIDTH(13)) axi_a ();
  axi_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DWB), .ID_WIDTH(13)) axi_b ();

  axi_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(13), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .entry(entry), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .halted(halted), .fetch_err(fetch_err), .m_axi(axi_a)
  );

  axi_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DWB), .ID_WIDTH(13), .BURST_LEN(BLB), .FIFO_DEPTH(FDB)) dut_b (
    .clk(clk), .reset(reset_b), .entry(entry_b), .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b),
    .instr_valid(instr_valid_b), .instr_ready(instr_ready_b), .instr_data(instr_data_b), .instr_pc(instr_pc_b),
    .halted(halted_b), .fetch_err(fetch_err_b), .m_axi(axi_b)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ a[31:0] ^ a[63:32];
  endfunction

  // Memory slave for the 64-bit unit; handshakes are decided on the negedge before the edge.
  int            zero_beat = -1;
  int            err_beat = -1;
  logic          busy_a = 1'b0;
  int            beat_a = 0;
  logic [AW-1:0] base_a = '0;
  logic          ar_hs_a = 1'b0, r_hs_a = 1'b0;
  logic [AW-1:0] ar_q_a = '0;
  logic [AW-1:0] ar_log[$];
  logic [AW-1:0] got_pc[$];
  logic [31:0]   got_data[$];

  always @(negedge clk) begin
    if (reset) begin
      busy_a = 1'b0; beat_a = 0; ar_hs_a = 1'b0; r_hs_a = 1'b0;
      axi_a.arready = 1'b0; axi_a.rvalid = 1'b0; axi_a.rlast = 1'b0;
      axi_a.rdata = '0; axi_a.rresp = 2'b00; axi_a.rid = '0;
    end else begin
      if (r_hs_a) begin
        beat_a++;
        if (beat_a == BL) busy_a = 1'b0;
      end
      if (ar_hs_a) begin
        busy_a = 1'b1; beat_a = 0; base_a = ar_q_a;
        ar_log.push_back(ar_q_a);
      end
      axi_a.arready = !busy_a;
      axi_a.rvalid  = busy_a;
      axi_a.rlast   = busy_a && (beat_a == BL - 1);
      for (int i = 0; i < DW/32; i++)
        axi_a.rdata[32*i +: 32] = (beat_a == zero_beat) ? 32'h0 :
                                  mem_word(base_a + AW'(beat_a*(DW/8) + 4*i));
      axi_a.rresp = (busy_a && beat_a == err_beat) ? 2'b10 : 2'b00;
      ar_hs_a = axi_a.arvalid && axi_a.arready;
      r_hs_a  = axi_a.rvalid && axi_a.rready;
      ar_q_a  = axi_a.araddr;
    end
  end

  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr_data);
    end
  end

  // Memory slave and consumer for the 128-bit, 4-beat unit.
  logic          busy_b = 1'b0;
  int            beat_b = 0;
  logic [AW-1:0] base_b = '0;
  logic          ar_hs_b = 1'b0, r_hs_b = 1'b0;
  logic [AW-1:0] ar_q_b = '0;
  logic [AW-1:0] ar_log_b[$];
  logic [AW-1:0] got_pc_b[$];
  logic [31:0]   got_data_b[$];

  always @(negedge clk) begin
    if (reset_b) begin
      busy_b = 1'b0; beat_b = 0; ar_hs_b = 1'b0; r_hs_b = 1'b0;
      axi_b.arready = 1'b0; axi_b.rvalid = 1'b0; axi_b.rlast = 1'b0;
      axi_b.rdata = '0; axi_b.rresp = 2'b00; axi_b.rid = '0;
    end else begin
      if (instr_valid_b && got_pc_b.size() < 32) begin
        got_pc_b.push_back(instr_pc_b);
        got_data_b.push_back(instr_data_b);
      end
      if (r_hs_b) begin
        beat_b++;
        if (beat_b == BLB) busy_b = 1'b0;
      end
      if (ar_hs_b) begin
        busy_b = 1'b1; beat_b = 0; base_b = ar_q_b;
        ar_log_b.push_back(ar_q_b);
      end
      axi_b.arready = !busy_b;
      axi_b.rvalid  = busy_b;
      axi_b.rlast   = busy_b && (beat_b == BLB - 1);
      for (int i = 0; i < DWB/32; i++)
        axi_b.rdata[32*i +: 32] = mem_word(base_b + AW'(beat_b*(DWB/8) + 4*i));
      ar_hs_b = axi_b.arvalid && axi_b.arready;
      r_hs_b  = axi_b.rvalid && axi_b.rready;
      ar_q_b  = axi_b.araddr;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] ar_at(input int i);
    return (i < ar_log.size()) ? ar_log[i] : '1;
  endfunction

  function automatic logic [AW-1:0] pc_at(input int i);
    return (i < got_pc.size()) ? got_pc[i] : '1;
  endfunction

  task automatic chk_seq(input string name, input int first, input int n, input logic [AW-1:0] start);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      if (first + k >= got_pc.size()) bad++;
      else if (got_pc[first+k] != start + AW'(4*k) ||
               got_data[first+k] != mem_word(start + AW'(4*k))) bad++;
    end
    chk(name, 64'(bad), 64'd0);
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int c = 0;
    while (got_pc.size() < n && c < budget) begin
      @(posedge clk); #1; c++;
    end
    chk(name, 64'(got_pc.size() >= n), 64'd1);
  endtask

  task automatic wait_ar(input int n, input int budget, input string name);
    int c = 0;
    while (ar_log.size() < n && c < budget) begin
      @(posedge clk); #1; c++;
    end
    chk(name, 64'(ar_log.size() >= n), 64'd1);
  endtask

  task automatic do_reset(input logic [AW-1:0] e, input bit check_state);
    @(posedge clk); #1;
    reset = 1'b1; entry = e; redirect_valid = 1'b0; instr_ready = 1'b0;
    @(posedge clk); #1;
    if (check_state) begin
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      chk("rst_arvalid",     64'(axi_a.arvalid), 64'd0);
      chk("rst_rready",      64'(axi_a.rready), 64'd0);
      chk("rst_halted",      64'(halted), 64'd0);
      chk("rst_fetch_err",   64'(fetch_err), 64'd0);
    end
    @(posedge clk); #1;
    got_pc.delete(); got_data.delete(); ar_log.delete();
    reset = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [AW-1:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] entry;
    logic [AW-1:0] ar0;
    int            nwords;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n0;
    int stale;
    int c;
    vecs[0] = '{64'h1000, 64'h1000, 16};
    vecs[1] = '{64'h1010, 64'h1000, 20};
    vecs[2] = '{64'h1038, 64'h1000, 6};
    vecs[3] = '{64'h2044, 64'h2040, 8};

    do_reset(64'h1000, 1'b1);
    reset_b = 1'b0;

    // Aligned and unaligned entry points: first AR, first PC, stream order, next AR.
    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].entry, 1'b0);
      instr_ready = 1'b1;
      wait_words(vecs[v].nwords, 400, $sformatf("vec%0d_words", v));
      wait_ar(2, 400, $sformatf("vec%0d_ar_count", v));
      chk($sformatf("vec%0d_ar0", v), ar_at(0), vecs[v].ar0);
      chk($sformatf("vec%0d_first_pc", v), pc_at(0), vecs[v].entry);
      chk_seq($sformatf("vec%0d_seq", v), 0, vecs[v].nwords, vecs[v].entry);
      chk($sformatf("vec%0d_ar1", v), ar_at(1), vecs[v].ar0 + 64'h40);
    end

    // Consumer stalled: buffer fills with exactly two bursts, then the stream resumes intact.
    do_reset(64'h1000, 1'b0);
    repeat (200) @(posedge clk);
    #1;
    chk("bp_ar_count", 64'(ar_log.size()), 64'(FD / (BL * (DW/32))));
    chk("bp_no_output", 64'(got_pc.size()), 64'd0);
    chk("bp_valid_held", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    wait_words(48, 1000, "bp_words");
    chk_seq("bp_seq", 0, 48, 64'h1000);

    // Redirect coinciding with beat 3 of the first burst.
    do_reset(64'h1000, 1'b0);
    instr_ready = 1'b1;
    c = 0;
    while (!(busy_a && beat_a == 2) && c < 200) begin
      @(posedge clk); #1; c++;
    end
    chk("redir_sync", 64'(busy_a && beat_a == 2), 64'd1);
    pulse_redirect(64'h2000);
    chk("redir_flush", 64'(instr_valid), 64'd0);
    n0 = got_pc.size();
    stale = 0;
    for (int k = 0; k < n0; k++) if (got_pc[k] >= 64'h1018) stale++;
    wait_words(n0 + 16, 600, "redir_words");
    chk("redir_stale", 64'(stale), 64'd0);
    chk("redir_ar1", ar_at(1), 64'h2000);
    chk_seq("redir_seq", n0, 16, 64'h2000);

    // Zero beat 5 halts fetch; a redirect restarts it.
    zero_beat = 5;
    do_reset(64'h1000, 1'b0);
    instr_ready = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("zero_words", 64'(got_pc.size()), 64'd10);
    chk_seq("zero_seq", 0, 10, 64'h1000);
    chk("zero_halted", 64'(halted), 64'd1);
    chk("zero_fetch_err", 64'(fetch_err), 64'd0);
    chk("zero_ar_count", 64'(ar_log.size()), 64'd1);
    chk("zero_arvalid", 64'(axi_a.arvalid), 64'd0);
    zero_beat = -1;
    pulse_redirect(64'h3000);
    chk("zero_halt_clear", 64'(halted), 64'd0);
    n0 = got_pc.size();
    wait_words(n0 + 16, 600, "zero_restart_words");
    chk("zero_ar1", ar_at(1), 64'h3000);
    chk_seq("zero_restart_seq", n0, 16, 64'h3000);

    // Error response on beat 2.
    err_beat = 2;
    do_reset(64'h1000, 1'b0);
    instr_ready = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("err_fetch_err", 64'(fetch_err), 64'd1);
    chk("err_halted", 64'(halted), 64'd1);
    chk("err_words", 64'(got_pc.size()), 64'd4);
    chk("err_ar_count", 64'(ar_log.size()), 64'd1);
    err_beat = -1;
    do_reset(64'h1000, 1'b1);

    // Wide-bus unit: 0x40 line step, four words per beat in address order.
    c = 0;
    while (got_pc_b.size() < 32 && c < 1000) begin
      @(posedge clk); #1; c++;
    end
    chk("wide_words", 64'(got_pc_b.size() >= 32), 64'd1);
    chk("wide_ar0", (ar_log_b.size() > 0) ? ar_log_b[0] : '1, 64'h1000);
    chk("wide_ar1", (ar_log_b.size() > 1) ? ar_log_b[1] : '1, 64'h1040);
    stale = 0;
    for (int k = 0; k < 32; k++) begin
      if (k >= got_pc_b.size()) stale++;
      else if (got_pc_b[k] != 64'h1000 + AW'(4*k) ||
               got_data_b[k] != mem_word(64'h1000 + AW'(4*k))) stale++;
    end
    chk("wide_seq", 64'(stale), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
